eth_tx_framer: RTL and testbench

//  Downstream of the length-prefixed byte source: consumes {len_hi, len_lo, payload...} bytes over AXI-Stream.

---
 rtl/eth_tx_framer.sv | 250 +++++++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: turns {len_hi, len_lo, payload} AXI-Stream messages into
// preamble/SFD/DA/SA/len/payload/pad frames. Define ETH_TX_FCS_EN to append CRC-32 FCS.
module eth_tx_framer #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [7:0]  s_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [7:0]  m_tdata,
  output logic        busy,
  output logic        frame_done,
  output logic        err_len,
  output logic [15:0] frame_cnt
);

  typedef enum logic [3:0] {
    StIdle, StLenLo, StPreamble, StHeader, StPayload, StPad, StFcs, StIfg, StDrain
  } state_e;

  localparam logic [15:0] MinLen  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MaxLen  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IfgLast = 16'(IFG_CYCLES - 1);

`ifdef ETH_TX_FCS_EN
  localparam bit     FcsEn  = 1'b1;
  localparam state_e TailSt = StFcs;
`else
  localparam bit     FcsEn  = 1'b0;
  localparam state_e TailSt = StIfg;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] ifg_q, ifg_d;
  logic        empty_q, empty_d;
  logic        drain_q, drain_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        s_tready_c, m_tvalid_c, m_tlast_c, err_len_c;
  logic [7:0]  m_tdata_c;
  logic [15:0] cnt_inc, len_full;
  logic        pay_end;
  logic [111:0] hdr_w, hdr_sh;

  assign cnt_inc  = cnt_q + 16'd1;
  assign len_full = {len_q[15:8], s_tdata};
  assign pay_end  = s_tlast || (cnt_inc == len_q);
  assign hdr_w    = {DST_MAC, SRC_MAC, len_q};
  assign hdr_sh   = hdr_w << {idx_q, 3'b000};

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc_q, crc_d, crc_inv, fcs_sh;

  // Reflected CRC-32 (0x04C11DB7 bit-reversed), LSB of each byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (state_q == StPreamble) begin
      crc_d = '1;
    end else if (m_tvalid_c && m_tready && (state_q inside {StHeader, StPayload, StPad})) begin
      crc_d = crc32_byte(crc_q, m_tdata_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_q <= '1;
    else          crc_q <= crc_d;
  end

  assign crc_inv = ~crc_q;
  assign fcs_sh  = crc_inv >> {idx_q[1:0], 3'b000};
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ifg_d      = ifg_q;
    empty_d    = empty_q;
    drain_d    = drain_q;
    s_tready_c = 1'b0;
    m_tvalid_c = 1'b0;
    m_tlast_c  = 1'b0;
    m_tdata_c  = 8'h00;
    err_len_c  = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_tready_c = 1'b1;
        if (s_tvalid) begin
          len_d[15:8] = s_tdata;
          if (s_tlast) err_len_c = 1'b1;
          else         state_d   = StLenLo;
        end
      end
      StLenLo: begin
        s_tready_c = 1'b1;
        if (s_tvalid) begin
          len_d   = len_full;
          idx_d   = '0;
          cnt_d   = '0;
          drain_d = 1'b0;
          if (len_full > MaxLen) begin
            err_len_c = 1'b1;
            state_d   = s_tlast ? StIdle : StDrain;
          end else begin
            empty_d = s_tlast;
            state_d = StPreamble;
          end
        end
      end
      StPreamble: begin
        m_tvalid_c = 1'b1;
        m_tdata_c  = (idx_q == 4'd7) ? 8'hD5 : 8'h55;
        if (m_tready) begin
          if (idx_q == 4'd7) begin
            idx_d   = '0;
            state_d = StHeader;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StHeader: begin
        m_tvalid_c = 1'b1;
        m_tdata_c  = hdr_sh[111:104];
        if (m_tready) begin
          if (idx_q == 4'd13) begin
            idx_d   = '0;
            state_d = (empty_q || (len_q == 16'd0)) ? StPad : StPayload;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StPayload: begin
        m_tvalid_c = s_tvalid;
        s_tready_c = m_tready;
        m_tdata_c  = s_tdata;
        m_tlast_c  = !FcsEn && pay_end && (cnt_inc >= MinLen);
        if (s_tvalid && m_tready) begin
          cnt_d = cnt_inc;
          if (pay_end) begin
            // Short message, or length reached without s_tlast (rest gets drained).
            if ((cnt_inc != len_q) || !s_tlast) err_len_c = 1'b1;
            if (!s_tlast) drain_d = 1'b1;
            idx_d   = '0;
            ifg_d   = '0;
            state_d = (cnt_inc >= MinLen) ? TailSt : StPad;
          end
        end
      end
      StPad: begin
        m_tvalid_c = 1'b1;
        m_tlast_c  = !FcsEn && (cnt_inc >= MinLen);
        if (m_tready) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= MinLen) begin
            idx_d   = '0;
            ifg_d   = '0;
            state_d = TailSt;
          end
        end
      end
`ifdef ETH_TX_FCS_EN
      StFcs: begin
        m_tvalid_c = 1'b1;
        m_tdata_c  = fcs_sh[7:0];
        m_tlast_c  = (idx_q == 4'd3);
        if (m_tready) begin
          if (idx_q == 4'd3) begin
            ifg_d   = '0;
            state_d = StIfg;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`endif
      StIfg: begin
        if (ifg_q == IfgLast) state_d = drain_q ? StDrain : StIdle;
        else                  ifg_d   = ifg_q + 16'd1;
      end
      StDrain: begin
        s_tready_c = 1'b1;
        if (s_tvalid && s_tlast) begin
          drain_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign frame_done  = m_tvalid_c && m_tready && m_tlast_c;
  assign frame_cnt_d = frame_cnt_q + {15'd0, frame_done};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      ifg_q       <= '0;
      empty_q     <= 1'b0;
      drain_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ifg_q       <= ifg_d;
      empty_q     <= empty_d;
      drain_q     <= drain_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // IDLE is ready, but nothing may be accepted or flagged while reset is held.
  assign s_tready  = s_tready_c & reset_n;
  assign err_len   = err_len_c & reset_n;
  assign m_tvalid  = m_tvalid_c;
  assign m_tlast   = m_tlast_c;
  assign m_tdata   = m_tdata_c;
  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: randomized AXI-Stream traffic compared
// against a byte-queue frame model built from the framing rules.
module tb_eth_tx_framer;

  localparam logic [47:0] DstMac = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SrcMac = 48'h0200_0000_0001;
  localparam int MinPay = 46;
  localparam int MaxPay = 1500;
  localparam int Ifg    = 12;
`ifdef ETH_TX_FCS_EN
  localparam int FcsLen = 4;
`else
  localparam int FcsLen = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [7:0]  m_tdata;
  logic        busy, frame_done, err_len;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  eth_tx_framer #(
    .DST_MAC    (DstMac),
    .SRC_MAC    (SrcMac),
    .MIN_PAYLOAD(MinPay),
    .MAX_PAYLOAD(MaxPay),
    .IFG_CYCLES (Ifg)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .s_tdata   (s_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tdata   (m_tdata),
    .busy      (busy),
    .frame_done(frame_done),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] msg[$];
  logic [7:0] in_data[$];
  logic       in_last[$];
  logic       in_lenlo[$];
  int         in_pos;
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         exp_err, err_seen, exp_frames;
  bit         gaps, rdy_rand, lat_en, lat_arm, s_hold;
  bit         stall_prev, stall_last, gap_mode;
  logic [7:0] stall_data;
  int         gap, last_gap, out_cnt, last_frame_len;

  // Model: queue the input bytes and the frame the spec says must come out.
  task automatic add_msg();
    int n, len, plen, body;
    logic [7:0] fr[$];
    logic [31:0] crc;
    n = msg.size();
    for (int i = 0; i < n; i++) begin
      in_data.push_back(msg[i]);
      in_last.push_back(i == n - 1);
      in_lenlo.push_back(i == 1);
    end
    if (n < 2) begin exp_err++; return; end
    len = int'({msg[0], msg[1]});
    if (len > MaxPay) begin exp_err++; return; end
    plen = (n - 2 < len) ? n - 2 : len;
    if (n > 2 && n - 2 != len) exp_err++;
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(8'(DstMac >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) fr.push_back(8'(SrcMac >> (40 - 8 * i)));
    fr.push_back(msg[0]);
    fr.push_back(msg[1]);
    for (int i = 0; i < plen; i++) fr.push_back(msg[2 + i]);
    while (fr.size() < 22 + MinPay) fr.push_back(8'h00);
    body = fr.size();
    crc = '1;
    for (int i = 8; i < body; i++) begin
      crc = crc ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < FcsLen; i++) fr.push_back(crc[8 * i +: 8]);
    for (int i = 0; i < fr.size(); i++) begin
      exp_data.push_back(fr[i]);
      exp_last.push_back(i == fr.size() - 1);
    end
    exp_frames++;
  endtask

  task automatic mk_hello();
    string s;
    s = "HELLO WORLD";
    msg.delete();
    msg.push_back(8'h00);
    msg.push_back(8'd11);
    for (int i = 0; i < 11; i++) msg.push_back(s[i]);
  endtask

  task automatic clear_model();
    in_data.delete(); in_last.delete(); in_lenlo.delete(); in_pos = 0;
    exp_data.delete(); exp_last.delete();
    exp_err = 0; err_seen = 0; exp_frames = 0;
    s_hold = 0; stall_prev = 0; gap_mode = 0; out_cnt = 0; lat_arm = 0;
  endtask

  task automatic step();
    bit in_acc, m_hs, exp_fd, e_last;
    @(negedge clk);
    if (!s_hold) begin
      if (in_pos < in_data.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
        s_tvalid = 1'b1;
        s_tdata  = in_data[in_pos];
        s_tlast  = in_last[in_pos];
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
        s_tlast  = 1'b0;
      end
    end
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (lat_arm) begin
      check("first_byte_latency", 32'({m_tvalid, m_tdata}), 32'h155);
      lat_arm = 0;
    end
    if (gap_mode) begin
      if (!s_tready) begin
        gap++;
        check("ifg_quiet", 32'(m_tvalid), 0);
      end else begin
        gap_mode = 0;
        last_gap = gap;
      end
    end
    in_acc = s_tvalid && s_tready;
    if (in_acc) begin
      if (lat_en && in_lenlo[in_pos]) lat_arm = 1;
      in_pos++;
    end
    s_hold = s_tvalid && !in_acc;
    if (stall_prev) begin
      check("stall_valid", 32'(m_tvalid), 1);
      check("stall_data", 32'(m_tdata), 32'(stall_data));
      check("stall_last", 32'(m_tlast), 32'(stall_last));
    end
    m_hs = m_tvalid && m_tready;
    exp_fd = 0;
    if (exp_data.size() == 0) begin
      check("no_output", 32'(m_tvalid), 0);
    end else if (m_hs) begin
      e_last = exp_last.pop_front();
      check("out_data", 32'(m_tdata), 32'(exp_data.pop_front()));
      check("out_last", 32'(m_tlast), 32'(e_last));
      exp_fd = e_last;
      out_cnt++;
      if (m_tlast) begin
        last_frame_len = out_cnt;
        out_cnt = 0;
        gap_mode = 1;
        gap = 0;
      end
    end
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (err_len) err_seen++;
    stall_prev = m_tvalid && !m_tready;
    stall_data = m_tdata;
    stall_last = m_tlast;
  endtask

  task automatic run(input int budget);
    int c;
    c = 0;
    while ((in_pos < in_data.size() || exp_data.size() != 0 || busy) && c < budget) begin
      step();
      c++;
    end
    check("run_complete", 32'(in_data.size() - in_pos + exp_data.size()) + 32'(busy), 0);
  endtask

  task automatic scen_end(input string tag);
    check($sformatf("%s_err_len", tag), err_seen, exp_err);
    check($sformatf("%s_frame_cnt", tag), 32'(frame_cnt), 32'(exp_frames[15:0]));
  endtask

  initial begin
    int len, plen, kind, total, c;
    s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 0; reset_n = 0;
    gaps = 0; rdy_rand = 0; lat_en = 0; last_gap = -1; last_frame_len = 0;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_s_tready", 32'(s_tready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_err_len", 32'(err_len), 0);
    reset_n = 1;

    // HELLO WORLD, full throughput
    mk_hello(); lat_en = 1; add_msg(); run(400); lat_en = 0;
    check("s1_frame_len", last_frame_len, 68 + FcsLen);
    scen_end("s1");

    // len=0, s_tlast on len_lo
    msg = '{8'h00, 8'h00}; add_msg(); run(400);
    check("s2_frame_len", last_frame_len, 68 + FcsLen);
    scen_end("s2");

    // oversize lengths and a 1-byte message, then a good one
    msg = '{8'h05, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44}; add_msg();
    msg = '{8'hAB}; add_msg();
    msg = '{8'h05, 8'hDD}; add_msg();
    run(400);
    scen_end("s3_reject");
    mk_hello(); add_msg(); run(400);
    scen_end("s3_after");

    // short message (5 of 11 bytes), then normal
    msg = '{8'h00, 8'd11, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F}; add_msg(); run(400);
    check("s4_frame_len", last_frame_len, 68 + FcsLen);
    scen_end("s4_short");
    mk_hello(); add_msg(); run(400);
    scen_end("s4_after");

    // long message: length reached without s_tlast, remainder drained
    msg = '{8'h00, 8'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5}; add_msg();
    mk_hello(); add_msg(); run(800);
    scen_end("long");

    // random backpressure and source gaps
    gaps = 1; rdy_rand = 1;
    mk_hello(); add_msg(); run(1000);
    check("s5_frame_len", last_frame_len, 68 + FcsLen);
    scen_end("s5");

    // randomized message mix
    for (int k = 0; k < 10; k++) begin
      len = $urandom_range(0, 70);
      kind = $urandom_range(0, 3);
      if (len == 0) plen = 0;
      else if (kind == 0 && len > 1) plen = $urandom_range(1, len - 1);
      else if (kind == 1) plen = len + $urandom_range(1, 3);
      else plen = len;
      msg.delete();
      msg.push_back(8'(len >> 8));
      msg.push_back(8'(len));
      for (int i = 0; i < plen; i++) msg.push_back(8'($urandom));
      add_msg();
    end
    run(20000);
    scen_end("rand");

    // reset mid-HEADER
    gaps = 0; rdy_rand = 0;
    mk_hello(); add_msg();
    total = exp_data.size();
    c = 0;
    while (exp_data.size() > total - 12 && c < 200) begin step(); c++; end
    check("mid_header_reached", 32'(total - exp_data.size()), 12);
    reset_n = 0;
    #1;
    check("rst_mid_m_tvalid", 32'(m_tvalid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_frame_cnt", 32'(frame_cnt), 0);
    clear_model();
    s_tvalid = 0; s_tlast = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;

    // back-to-back after reset
    last_gap = -1;
    mk_hello(); add_msg();
    mk_hello(); add_msg();
    run(800);
    check("b2b_ifg_gap", last_gap, Ifg);
    check("b2b_frame_cnt_2", 32'(frame_cnt), 2);
    scen_end("b2b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
